timeout_timer: RTL
==================

# timeout_timer

Programmable one-shot down-counting timeout for the USB Type-C controller. The port state machines load a duration (0–999) and a unit (ns, us, ms, s, where one CLK cycle is 1 ns). The block asserts a one-cycle `expired` pulse after exactly that many cycles. It supports cancel and restart, and drives debounce and toggle timeouts such as tCCDebounce and tDRP.

## Interface
Parameters:
- `DW`, default 10: width of the duration and remaining-count fields.
- `SUB_MAX`, default 999: terminal value of each decade prescaler stage.

Ports:
- `CLK`, in, 1: clock. One cycle is one nanosecond.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: load `duration` and `unit`, then begin counting.
- `cancel`, in, 1: abort a running timeout with no `expired` pulse.
- `duration`, in, DW: number of units to wait. Sampled only on a `start` cycle.
- `unit`, in, 2: time unit. 0 = ns, 1 = us, 2 = ms, 3 = s. Sampled only on a `start` cycle.
- `busy`, out, 1: high while a timeout is running.
- `expired`, out, 1: one-cycle pulse when the timeout elapses.
- `remaining`, out, DW: whole units left to count.

## Operation
- States: IDLE and RUN.
- On reset: go to IDLE. `busy`=0, `expired`=0, `remaining`=0, all prescalers=0.
- Priority at each edge, highest first: reset, cancel, start, tick.
- Cancel:
  - Go to IDLE with `remaining`=0 and `expired`=0.
  - A `start` in the same cycle is ignored.
- Start with `duration`>0, from IDLE or RUN:
  - Set `remaining`=`duration`, latch `unit`, clear the prescalers, enter RUN.
  - From RUN this is a restart: it reloads and discards the old count.
- Start with `duration`=0:
  - Stay in (or return to) IDLE and pulse `expired` on the next cycle.
  - `busy` never rises.
- Prescaler chain in RUN (stages p0, p1, p2, each 0..SUB_MAX):
  - p0 increments every cycle.
  - p1 increments when p0=SUB_MAX.
  - p2 increments when p0=p1=SUB_MAX.
  - Each stage wraps to 0 after SUB_MAX.
- Unit tick:
  - ns: every cycle.
  - us: when p0=SUB_MAX.
  - ms: when p0=p1=SUB_MAX.
  - s: when p0=p1=p2=SUB_MAX.
- On each tick in RUN:
  - `remaining` decrements by 1.
  - If `remaining` was 1: go to IDLE, `expired`<=1, `remaining`<=0.
- `expired` is registered and held high for exactly one cycle.
- In IDLE the prescalers hold at 0.
- Arithmetic: `remaining` never underflows, and the prescalers never exceed SUB_MAX.

## Timing
- Let K = 1, 1000, 10^6 or 10^9 for ns, us, ms or s.
- `start` sampled at edge 0 with duration D>0:
  - `busy`=1 from edge 0 through edge D·K.
  - `expired`=1 for the single cycle following edge D·K.
  - `busy` falls on that same edge.
- `remaining` equals D after edge 0 and steps down after each tick edge.
- Zero duration: `expired` high for the cycle following edge 0.
- Expiry and `start` on the same edge: the restart wins and `expired` is not asserted.
- Expiry and `cancel` on the same edge: the cancel wins and `expired` is not asserted.
- Reset in the middle of a run takes effect at the next edge: all outputs return to reset values and no `expired` pulse is produced.

## Structure
- Shared package `usb_timer_pkg` holds:
  - Unit encodings: UNIT_NS, UNIT_US, UNIT_MS, UNIT_S.
  - SUB_MAX=999.
  - The state enum: ST_IDLE, ST_RUN.
- Sub-module `decade_prescaler`, instantiated three times:
  - Inputs: `clr`, `en`.
  - Behaviour: counts 0..SUB_MAX when enabled, `clr` forces 0.
  - Output `wrap` is high when the count is SUB_MAX and `en` is high.
- Top level holds:
  - The state register and the tick-select mux.
  - The `remaining` down-counter.
  - The `expired` register.

## Test plan
- unit=ns, D=5, start at edge 0 → `busy` high over edges 0–5. `expired` high for one cycle after edge 5. `remaining` steps 5,4,3,2,1,0.
- unit=us, D=3 → `expired` exactly 3000 cycles after start. `remaining`=2 after cycle 1000 and 1 after cycle 2000.
- D=0, unit=ms → `expired` pulse the cycle after start; `busy` stays 0.
- unit=us, D=2, `cancel` at cycle 500 → `busy`=0 and `remaining`=0 from the next cycle; no `expired` ever.
- unit=ns, D=10, restart with D=4 at cycle 7 → `expired` at cycle 11 only, not at cycle 10. Also `start` and `cancel` in the same cycle → IDLE, no load.
- unit=ms, D=1, `reset` at cycle 400 → all outputs 0 the next cycle; no `expired` at cycle 10^6.

Source files
------------

// File: rtl/usb_timer_pkg.sv
// -----------------------------------------------------------------------------
// usb_timer_pkg
//   Shared definitions for the Type-C port timers.
//   - UNIT_* : encodings of the `unit` input (ns / us / ms / s).
//   - SUB_MAX: terminal count of one decade prescaler stage (1000 states).
//   - state_t: run state of a timeout timer.
//   - unit_tick(): selects the tick strobe that matches the latched unit.
// -----------------------------------------------------------------------------
package usb_timer_pkg;

   localparam logic [1:0] UNIT_NS = 2'd0;
   localparam logic [1:0] UNIT_US = 2'd1;
   localparam logic [1:0] UNIT_MS = 2'd2;
   localparam logic [1:0] UNIT_S  = 2'd3;

   localparam int SUB_MAX = 999;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // run  : timer is counting (ns tick = every running cycle)
   // wrap : wrap strobes of prescaler stages 0..2 (already qualified by
   //        their enables, so wrap[n] means "a 10^(3(n+1)) ns boundary").
   function automatic logic unit_tick(input logic [1:0] unit_sel,
                                      input logic       run,
                                      input logic [2:0] wrap);
      logic tick;
      tick = 1'b0;
      case (unit_sel)
         UNIT_NS: tick = run;
         UNIT_US: tick = wrap[0];
         UNIT_MS: tick = wrap[1];
         UNIT_S:  tick = wrap[2];
         default: tick = 1'b0;
      endcase
      return tick;
   endfunction

endpackage

// File: rtl/decade_prescaler.sv
// -----------------------------------------------------------------------------
// decade_prescaler
//   One stage of the ns -> us -> ms -> s prescaler chain. Counts 0..SUB_MAX
//   while enabled and wraps back to 0.
//
//   Ports:
//     CLK   in  clock
//     reset in  synchronous active-high reset (count -> 0)
//     clr   in  synchronous clear, overrides en (count -> 0)
//     en    in  advance the count this cycle
//     wrap  out high when the count is at SUB_MAX and en is high, i.e. the
//               stage rolls over on this edge; used to enable the next stage
// -----------------------------------------------------------------------------
module decade_prescaler #(
   parameter int SUB_MAX = usb_timer_pkg::SUB_MAX
) (
   input  logic CLK,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic wrap
);

   localparam int             CW      = $clog2(SUB_MAX + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(SUB_MAX);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         // >= rather than == so a corrupted count can never climb past max
         if (cnt_q >= CNT_MAX) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign wrap = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/timeout_timer.sv
// -----------------------------------------------------------------------------
// timeout_timer
//   Programmable one-shot down-counting timeout (tCCDebounce, tDRP, ...).
//   A start loads `duration` units of `unit`; after exactly duration*K cycles
//   (K = 1, 10^3, 10^6, 10^9 with the default SUB_MAX) a one-cycle `expired`
//   pulse is produced. Cancel aborts silently; a start while running restarts.
//   A start with duration 0 pulses `expired` on the next cycle without ever
//   raising `busy`.
//
//   Ports:
//     CLK       in   clock, one cycle = 1 ns
//     reset     in   synchronous active-high reset
//     start     in   load duration/unit and begin counting
//     cancel    in   abort a running timeout (wins over start)
//     duration  in   DW  number of units, sampled on start only
//     unit      in   2   0=ns 1=us 2=ms 3=s, sampled on start only
//     busy      out  high while a timeout is running
//     expired   out  registered one-cycle pulse when the timeout elapses
//     remaining out  DW  whole units left to count
// -----------------------------------------------------------------------------
module timeout_timer #(
   parameter int DW      = 10,
   parameter int SUB_MAX = usb_timer_pkg::SUB_MAX
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          start,
   input  logic          cancel,
   input  logic [DW-1:0] duration,
   input  logic [1:0]    unit,
   output logic          busy,
   output logic          expired,
   output logic [DW-1:0] remaining
);

   import usb_timer_pkg::*;

   state_t        state_q;
   state_t        state_d;
   logic [DW-1:0] rem_q;
   logic [DW-1:0] rem_d;
   logic [1:0]    unit_q;
   logic [1:0]    unit_d;
   logic          exp_q;
   logic          exp_d;

   logic          run;
   logic          tick;
   logic          pre_clr;
   logic [2:0]    pre_en;
   logic [2:0]    pre_wrap;

   assign run = (state_q == ST_RUN);

   // ------------------------------------------------------------------
   // Prescaler chain: stage 0 counts every running cycle, each later stage
   // advances only when all earlier stages roll over together.
   // Cleared whenever the next state is not RUN (cancel, expiry, zero-length
   // start, idle) and on every start so a restart begins on a fresh boundary.
   // ------------------------------------------------------------------
   assign pre_clr = start || (state_d != ST_RUN);

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_pre
         if (gi == 0) begin : g_first
            assign pre_en[gi] = run;
         end else begin : g_next
            assign pre_en[gi] = pre_wrap[gi-1];
         end

         decade_prescaler #(
            .SUB_MAX (SUB_MAX)
         ) u_pre (
            .CLK   (CLK),
            .reset (reset),
            .clr   (pre_clr),
            .en    (pre_en[gi]),
            .wrap  (pre_wrap[gi])
         );
      end
   endgenerate

   assign tick = unit_tick(unit_q, run, pre_wrap);

   // ------------------------------------------------------------------
   // Next-state logic. Priority: cancel, start, tick (reset in the register).
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      unit_d  = unit_q;
      exp_d   = 1'b0;

      if (cancel) begin
         state_d = ST_IDLE;
         rem_d   = '0;
      end else if (start) begin
         if (duration != '0) begin
            state_d = ST_RUN;
            rem_d   = duration;
            unit_d  = unit;
         end else begin
            state_d = ST_IDLE;
            rem_d   = '0;
            exp_d   = 1'b1;
         end
      end else if (run && tick) begin
         // <= 1 also covers an impossible zero count, so no underflow
         if (rem_q <= DW'(1)) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            exp_d   = 1'b1;
         end else begin
            rem_d   = rem_q - DW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         unit_q  <= UNIT_NS;
         exp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         unit_q  <= unit_d;
         exp_q   <= exp_d;
      end
   end

   assign busy      = run;
   assign expired   = exp_q;
   assign remaining = rem_q;

endmodule
